// File: rtl/neighbor_pkg.sv
// neighbor_pkg: definitions shared by neighbor_counter and the downstream
// result-routing multiplexer.
//   - FSM state encoding (ST_*) and the enum built on it.
//   - Result codes (RES_*) that the multiplexer decodes from res.
package neighbor_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ACCUM = ST_ACCUM,
    S_DONE  = ST_DONE
  } state_t;

  // Counts the multiplexer singles out; every other value takes its default path.
  localparam int unsigned RES_ONE   = 32'd1;
  localparam int unsigned RES_THREE = 32'd3;

endpackage

// File: rtl/neighbor_counter_window_counter.sv
// window_counter: sample index within the current window.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return the index to 0 (takes priority over inc)
//   inc        : advance the index by one accepted sample
//   last       : high while the index sits at COUNT-1, i.e. the next
//                accepted sample closes the window
module window_counter #(
  parameter int COUNT = 8,
  parameter int IW    = $clog2(COUNT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [IW-1:0] idx_r;

  // Index register: clear wins over increment, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= {IW{1'b0}};
    end else if (clr) begin
      idx_r <= {IW{1'b0}};
    end else if (inc) begin
      idx_r <= idx_r + IW'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  assign last = (idx_r == IW'(COUNT - 1));

endmodule

// File: rtl/neighbor_counter.sv
// neighbor_counter: counts the ones in a serial window of COUNT neighbour
// bits and hands the count to the result-routing multiplexer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : open a new window (looked at in IDLE only)
//   in_valid   : in_bit carries a sample this cycle
//   in_bit     : neighbour sample, 1 = alive/set
//   abort      : (NEIGHBOR_COUNTER_ABORT_EN only) drop the window in progress
//   in_ready   : a sample is accepted this cycle when in_valid is high
//   busy       : window in progress (ACCUM or DONE)
//   res        : ones-count of the last completed window
//   enable     : one-cycle pulse announcing a fresh res
// Optional build macro: NEIGHBOR_COUNTER_ABORT_EN adds the abort input.
module neighbor_counter
  import neighbor_pkg::*;
#(
  parameter int SIZE  = 5,
  parameter int COUNT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  input  logic            in_bit,
`ifdef NEIGHBOR_COUNTER_ABORT_EN
  input  logic            abort,
`endif
  output logic            in_ready,
  output logic            busy,
  output logic [SIZE-1:0] res,
  output logic            enable
);

  localparam int IW = $clog2(COUNT + 1);

  // COUNT must fit in res, otherwise the accumulator could wrap.
  if ((COUNT < 1) || (COUNT > ((2 ** SIZE) - 1))) begin : g_bad_count
    $error("neighbor_counter: COUNT must lie in 1 .. 2**SIZE-1");
  end

  state_t          state_r;
  logic [SIZE-1:0] acc_r;
  logic [SIZE-1:0] res_r;

  logic            accept_s;
  logic            abort_s;
  logic            cnt_clr_s;
  logic            cnt_inc_s;
  logic            last_s;
  logic [SIZE-1:0] sum_s;

  // Handshake, abort qualification and the running sum including this sample.
  always_comb begin
    accept_s = in_valid && (state_r == S_ACCUM);
`ifdef NEIGHBOR_COUNTER_ABORT_EN
    abort_s  = abort && (state_r == S_ACCUM);
`else
    abort_s  = 1'b0;
`endif
    sum_s     = acc_r + SIZE'(in_bit);
    // Abort beats a sample arriving in the same cycle.
    cnt_clr_s = ((state_r == S_IDLE) && start) || abort_s;
    cnt_inc_s = accept_s && !abort_s;
  end

  window_counter #(
    .COUNT (COUNT),
    .IW    (IW)
  ) u_window_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_s),
    .inc   (cnt_inc_s),
    .last  (last_s)
  );

  // Window FSM with accumulator and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      acc_r   <= {SIZE{1'b0}};
      res_r   <= {SIZE{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r <= S_ACCUM;
            acc_r   <= {SIZE{1'b0}};
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ACCUM: begin
          if (abort_s) begin
            state_r <= S_IDLE;
            acc_r   <= {SIZE{1'b0}};
          end else if (accept_s) begin
            acc_r <= sum_s;
            if (last_s) begin
              // The closing sample is folded straight into res.
              res_r   <= sum_s;
              state_r <= S_DONE;
            end else begin
              state_r <= S_ACCUM;
            end
          end else begin
            state_r <= S_ACCUM;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decode straight from the state register.
  assign in_ready = (state_r == S_ACCUM);
  assign busy     = (state_r != S_IDLE);
  assign enable   = (state_r == S_DONE);
  assign res      = res_r;

endmodule

// File: tb/tb_neighbor_counter.sv
// tb_neighbor_counter: directed windows with hand-computed counts. The
// stimulus pushes {count, cycle} for each completed window; a monitor pops
// and checks on every enable pulse.
module tb_neighbor_counter;

  localparam int SIZE  = 5;
  localparam int COUNT = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_bit = 1'b0;
  logic            abort = 1'b0;
  logic            in_ready;
  logic            busy;
  logic [SIZE-1:0] res;
  logic            enable;

  typedef struct {
    int res;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   hold_start = 1'b0;

  neighbor_counter #(.SIZE(SIZE), .COUNT(COUNT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_bit   (in_bit),
`ifdef NEIGHBOR_COUNTER_ABORT_EN
    .abort    (abort),
`endif
    .in_ready (in_ready),
    .busy     (busy),
    .res      (res),
    .enable   (enable)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every enable pulse must match the next expectation.
  always @(negedge clk) begin
    if (rst_n && enable) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_enable: got enable=1 expected none (cyc=%0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_res", int'(res), e.res);
        check("sb_enable_cycle", cyc, e.cyc);
      end
    end
  end

  // One window; entry and exit at posedge+1 with the DUT in IDLE.
  task automatic run_window(input logic [7:0] bits, input int exp_res,
                            input int stall_at, input int stall_len,
                            input int start_at, input int abort_at);
    start = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_start", int'(in_ready), 1);
    start = hold_start;
    for (int i = 0; i < COUNT; i++) begin
      if (i == stall_at) begin
        in_valid = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_bit   = bits[i];
      start    = (i == start_at) ? 1'b1 : hold_start;
      abort    = (i == abort_at) ? 1'b1 : 1'b0;
      if (i == abort_at) begin
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        start    = hold_start;
        check("abort_to_idle_busy", int'(busy), 0);
        return;
      end
      if (i == COUNT - 1) exp_q.push_back('{res: exp_res, cyc: cyc + 1});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = hold_start;
    check("done_busy", int'(busy), 1);
    @(posedge clk); #1;
    check("idle_after_done_busy", int'(busy), 0);
  endtask

  initial begin
    #3;
    check("reset_res", int'(res), 0);
    check("reset_enable", int'(enable), 0);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1,0,0,0,0,0,0,0
    run_window(8'b0000_0001, 1, -1, 0, -1, -1);
    // 1,1,0,1,0,0,0,0 with three stall cycles after sample 2
    run_window(8'b0000_1011, 3, 2, 3, -1, -1);

`ifdef NEIGHBOR_COUNTER_ABORT_EN
    // Abort on sample 6: no pulse, res keeps 3.
    run_window(8'b0011_1111, 0, -1, 0, -1, 5);
    check("abort_res_kept", int'(res), 3);
    repeat (3) begin
      @(posedge clk); #1;
    end
    // Next window must start from a clean index/acc.
    run_window(8'b0000_0011, 2, -1, 0, -1, -1);
`endif

    // Back-to-back windows with start held high.
    hold_start = 1'b1;
    run_window(8'b1111_1111, 8, -1, 0, -1, -1);
    run_window(8'b0000_0000, 0, -1, 0, -1, -1);
    hold_start = 1'b0;
    start = 1'b0;

    // start pulse at sample 5 is ignored.
    run_window(8'b1010_0101, 4, -1, 0, 4, -1);

    // Reset mid-window after four ones.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_res", int'(res), 0);
    check("midreset_enable", int'(enable), 0);
    check("midreset_in_ready", int'(in_ready), 0);
    check("midreset_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_window(8'b0000_0001, 1, -1, 0, -1, -1);

    repeat (4) begin
      @(posedge clk); #1;
    end
    check("sb_all_enables_seen", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/neighbor_counter.md
Name: neighbor_counter

Overview:
- Upstream producer for the result-routing multiplexer.
- Counts the ones in a serial window of COUNT neighbour bits.
- At window end, presents the count on res and asserts enable for exactly one cycle.
- The multiplexer decodes res (1, 3, other) and gates its outputs with enable.

Parameters:
- SIZE, 5, width of res; must equal the downstream multiplexer size.
- COUNT, 8, samples per window; legal range 1 to 2^SIZE-1.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a new window; sampled in IDLE only.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  neighbour sample; 1 means alive/set.
- in_ready  output  1  block accepts a sample this cycle.
- busy  output  1  window in progress (ACCUM or DONE).
- res  output  SIZE  ones-count of the last completed window.
- enable  output  1  one-cycle pulse: res holds a fresh result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; res=0; enable=0; in_ready=0; busy=0.
  - Internal acc=0; sample index=0.
  - Takes effect immediately, mid-window included. A partial window is discarded with no enable pulse.
- All outputs are registered or decoded from state. There is no combinational path from inputs to outputs.
- FSM has 3 states.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 -> ACCUM next cycle; acc and index cleared to 0.
- ACCUM:
  - in_ready=1, busy=1.
  - A sample is accepted on in_valid & in_ready; acc += in_bit; index += 1.
  - The cycle that accepts sample number COUNT goes to DONE.
  - res <= acc + in_bit on that same edge.
  - in_valid=0 stalls: no change, indefinitely.
- DONE:
  - enable=1 for exactly this one cycle; busy=1; in_ready=0.
  - Unconditionally -> IDLE next cycle.
- Latency and throughput:
  - start to in_ready: 1 cycle.
  - Last accepted sample to enable: 1 cycle.
  - Minimum window is COUNT+2 cycles, start included.
- Arithmetic:
  - acc is SIZE bits wide; index is clog2(COUNT+1) bits.
  - With legal COUNT, acc cannot overflow.
  - Illegal COUNT raises an elaboration-time error via a generate-time check.
- res holds its value from DONE until the next DONE or reset. It is never driven to z.
- enable is never asserted outside DONE.
- Boundary conditions:
  - start while ACCUM or DONE: ignored; the window is not restarted.
  - start held high continuously: windows run back-to-back. IDLE lasts 1 cycle between windows.
  - in_valid outside ACCUM: ignored; sample not counted.
  - COUNT=1: a single accepted sample goes directly to DONE.
  - All zeros gives res=0; all ones gives res=COUNT.

Optional Feature:
- Macro: NEIGHBOR_COUNTER_ABORT_EN.
- With the macro:
  - Extra input port abort (1 bit) is added.
  - abort=1 in ACCUM -> IDLE next cycle; acc and index are cleared.
  - No enable pulse; res keeps its previous value.
  - abort has priority over a sample accepted in the same cycle.
  - abort in IDLE or DONE is ignored.
- Without the macro: no abort port; a window always completes once COUNT samples arrive.

Decomposition:
- Shared package neighbor_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2.
  - Result code constants RES_ONE=1 and RES_THREE=3, shared with the downstream multiplexer decode.
- One sub-module is natural: window_counter. It holds the index counter with clear/increment and produces a last-sample flag at index==COUNT-1.
- The FSM and accumulator stay in the top block.

Test Plan:
- Reset mid-window: after 4 samples of 1, pull rst_n low asynchronously -> outputs 0 immediately, no enable pulse. The next window counts from 0.
- Pattern 1,0,0,0,0,0,0,0 (COUNT=8, in_valid always 1) -> enable pulses 1 cycle after the 8th sample with res=1. enable is low in every other cycle.
- Pattern 1,1,0,1,0,0,0,0 with in_valid deasserted for 3 cycles after sample 2 -> res=3. enable comes 1 cycle after the 8th accepted sample, not earlier.
- All-ones window -> res=8; all-zeros window -> res=0. start is held high throughout, so the two windows run back-to-back with exactly 1 IDLE cycle between.
- start pulsed during ACCUM at sample 5 -> ignored. res reflects all 8 samples and exactly one enable pulse occurs.
- With NEIGHBOR_COUNTER_ABORT_EN, abort at sample 6 of a window whose previous res=3 -> IDLE next cycle, no enable, res stays 3. Sample 6 is not counted.
